// File: rtl/trace_pkg.sv
// Shared types for the trace capture buffer.
//   trace_state_e : FSM encoding, also driven out on the state port
//   trace_entry_t : one captured {pc, instr} pair, same packing as debug_out
package trace_pkg;

  localparam int TRACE_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    DRAIN   = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Register-array storage for captured trace entries.
// One synchronous write port, one asynchronous (combinational) read port.
// The array is deliberately not reset; readers only look at written slots.
// Ports:
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write slot
//   wr_data : entry to store
//   rd_addr : read slot
//   rd_data : entry at rd_addr (combinational)
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_capture_buffer.sv
// Circular capture of retired {pc, instr} pairs with optional PC-match
// trigger and a valid/ready drain port that returns history oldest-first.
// Ports:
//   clk, rst          : clock, async active-high reset
//   trace_in/valid    : retired instruction stream ({pc, instr})
//   arm / stop        : start capture (IDLE) / end capture (CAPTURE)
//   trig_en / trig_pc : PC-match trigger
//   rd_valid/ready    : drain handshake; rd_data oldest unread entry
//   rd_last           : rd_data is the final entry of the capture
//   count             : entries held
//   overflow          : sticky, an entry was overwritten this capture
//   state             : current FSM state
//
// state   | meaning
// IDLE    | waiting for arm, trace input ignored
// CAPTURE | recording every valid entry, watching for trigger/stop
// POST    | recording a fixed number of entries after the trigger
// DRAIN   | writes inhibited, entries handed out over the read port
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int XLEN      = TRACE_XLEN,
  parameter int POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*XLEN-1:0]        trace_in,
  input  logic                     trace_valid,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [2*XLEN-1:0]        rd_data,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [1:0]               state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] POST_INIT = PTR_W'(POST_TRIG);

  trace_state_e     state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] post_cnt_q, post_cnt_d;
  logic             overflow_q, overflow_d;

  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr_w;
  logic [CNT_W-1:0] count_w;
  logic [PTR_W-1:0] drain_ptr;
  logic             trig_hit;
  logic             rd_fire;

  // Post-write pointer/count for this cycle; used both to update state and
  // to locate the oldest entry when switching into DRAIN on the same edge.
  assign wr_en     = (state_q == CAPTURE || state_q == POST) && trace_valid;
  assign wr_ptr_w  = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign count_w   = (wr_en && count_q != CNT_FULL) ? count_q + CNT_W'(1) : count_q;
  // count may equal DEPTH; truncation makes that a full lap back to wr_ptr.
  assign drain_ptr = wr_ptr_w - count_w[PTR_W-1:0];
  assign trig_hit  = trig_en && trace_valid && (trace_in[2*XLEN-1:XLEN] == trig_pc);

  assign rd_valid  = (state_q == DRAIN) && (count_q != '0);
  assign rd_last   = rd_valid && (count_q == CNT_W'(1));
  assign rd_fire   = rd_valid && rd_ready;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d    = CAPTURE;
          wr_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      CAPTURE: begin
        wr_ptr_d = wr_ptr_w;
        count_d  = count_w;
        if (wr_en && count_q == CNT_FULL) overflow_d = 1'b1;
        if (stop) begin
          if (count_w == '0) begin
            state_d = IDLE;
          end else begin
            state_d  = DRAIN;
            rd_ptr_d = drain_ptr;
          end
        end else if (trig_hit) begin
          if (POST_TRIG == 0) begin
            state_d  = DRAIN;
            rd_ptr_d = drain_ptr;
          end else begin
            state_d    = POST;
            post_cnt_d = POST_INIT;
          end
        end
      end
      POST: begin
        wr_ptr_d = wr_ptr_w;
        count_d  = count_w;
        if (wr_en) begin
          if (count_q == CNT_FULL) overflow_d = 1'b1;
          post_cnt_d = post_cnt_q - PTR_W'(1);
          if (post_cnt_q == PTR_W'(1)) begin
            state_d  = DRAIN;
            rd_ptr_d = drain_ptr;
          end
        end
      end
      DRAIN: begin
        if (rd_fire) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (trace_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
`timescale 1ns/100ps
module tb_trace_capture_buffer;
  import trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] trace_in;
  logic        trace_valid, arm, stop, trig_en, rd_ready;
  logic [31:0] trig_pc;
  logic        rd_valid, rd_last, overflow;
  logic [63:0] rd_data;
  logic [4:0]  count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  trace_capture_buffer #(.DEPTH(16), .XLEN(32), .POST_TRIG(4)) dut (
    .clk(clk), .rst(rst), .trace_in(trace_in), .trace_valid(trace_valid),
    .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .count(count), .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        arm, stop, tv, trig_en;
    logic [31:0] pc, trig_pc;
    logic [1:0]  e_state;
    logic [4:0]  e_count;
    logic        e_valid, e_ovf;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] entry_of(input logic [31:0] pc);
    trace_entry_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    arm = 0; stop = 0; trace_valid = 0; trig_en = 0; trig_pc = '0;
    rd_ready = 0; trace_in = '0;
  endtask

  task automatic feed(input logic [31:0] pc);
    trace_in    = entry_of(pc);
    trace_valid = 1;
    step();
    trace_valid = 0;
  endtask

  task automatic do_arm();
    arm = 1;
    step();
    arm = 0;
    check("arm_state", state, CAPTURE);
  endtask

  task automatic do_stop();
    stop = 1;
    step();
    stop = 0;
  endtask

  // Reads n entries starting at PC first_pc (step 4) out of a capture of
  // `total` entries. mode 1 drives rd_ready with the pattern 1,0,0,1.
  task automatic drain_check(input logic [31:0] first_pc, input int n, input int total,
                             input int mode);
    int received = 0;
    int cyc = 0;
    logic [31:0] exp_pc;
    while (received < n && cyc < 200) begin
      rd_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      exp_pc   = first_pc + 32'(received * 4);
      check("drain_valid", rd_valid, 1'b1);
      check("drain_data", rd_data, entry_of(exp_pc));
      if (rd_ready && rd_valid) begin
        check("drain_last", rd_last, received == total - 1);
        received++;
      end
      step();
      cyc++;
    end
    rd_ready = 0;
    check("drain_xfers", received, n);
    if (n == total) begin
      check("drain_end_state", state, IDLE);
      check("drain_end_valid", rd_valid, 1'b0);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #12 rst = 0;

    check("rst_state", state, IDLE);
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_last", rd_last, 0);
    check("rst_ovf", overflow, 0);

    // Test 1: arm, 10 entries, stop -- table driven.
    vecs[0] = '{arm:1, stop:0, tv:0, trig_en:0, pc:0, trig_pc:0,
                e_state:CAPTURE, e_count:0, e_valid:0, e_ovf:0};
    for (int i = 1; i <= 10; i++)
      vecs[i] = '{arm:0, stop:0, tv:1, trig_en:0, pc:32'((i-1)*4), trig_pc:0,
                  e_state:CAPTURE, e_count:5'(i), e_valid:0, e_ovf:0};
    vecs[11] = '{arm:0, stop:1, tv:0, trig_en:0, pc:0, trig_pc:0,
                 e_state:DRAIN, e_count:10, e_valid:1, e_ovf:0};
    for (int i = 0; i < 12; i++) begin
      arm = vecs[i].arm; stop = vecs[i].stop; trace_valid = vecs[i].tv;
      trig_en = vecs[i].trig_en; trig_pc = vecs[i].trig_pc;
      trace_in = entry_of(vecs[i].pc);
      step();
      check($sformatf("vec%0d_state", i), state, vecs[i].e_state);
      check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
      check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_ovf", i), overflow, vecs[i].e_ovf);
    end
    clear_inputs();
    drain_check(32'h00, 10, 10, 0);

    // Test 2: overflow and pointer wrap, drained with backpressure.
    do_arm();
    for (int i = 0; i < 20; i++) feed(32'(i*4));
    do_stop();
    check("ovf_state", state, DRAIN);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    drain_check(32'h10, 16, 16, 1);

    // Test 3: PC trigger at 0x20, 4 post entries, later PCs not stored.
    do_arm();
    check("rearm_ovf_clear", overflow, 0);
    trig_en = 1; trig_pc = 32'h20;
    for (int k = 0; k < 32; k++) begin
      feed(32'(k*4));
      check($sformatf("trig_state_k%0d", k), state,
            (k < 8) ? CAPTURE : (k < 12) ? POST : DRAIN);
      check($sformatf("trig_count_k%0d", k), count, (k < 13) ? 5'(k+1) : 5'd13);
    end
    trig_en = 0;
    drain_check(32'h00, 13, 13, 0);

    // Test 4: async reset mid-drain, then clean re-capture.
    do_arm();
    for (int i = 0; i < 8; i++) feed(32'h100 + 32'(i*4));
    do_stop();
    drain_check(32'h100, 3, 8, 0);
    check("pre_rst_count", count, 5);
    #2 rst = 1;
    #1;
    check("async_rst_state", state, IDLE);
    check("async_rst_valid", rd_valid, 0);
    check("async_rst_count", count, 0);
    rst = 0;
    #1;
    do_arm();
    for (int i = 0; i < 3; i++) feed(32'h200 + 32'(i*4));
    do_stop();
    check("recap_count", count, 3);
    drain_check(32'h200, 3, 3, 0);

    // Test 5a: arm ignored in DRAIN.
    do_arm();
    feed(32'h300); feed(32'h304);
    do_stop();
    arm = 1;
    step();
    arm = 0;
    check("drain_arm_state", state, DRAIN);
    check("drain_arm_count", count, 2);
    drain_check(32'h300, 2, 2, 0);

    // Test 5b: stop and trigger in the same cycle -> DRAIN, no POST.
    do_arm();
    trig_en = 1; trig_pc = 32'h40;
    feed(32'h3C);
    stop = 1;
    feed(32'h40);
    stop = 0; trig_en = 0;
    check("stop_trig_state", state, DRAIN);
    check("stop_trig_count", count, 2);
    drain_check(32'h3C, 2, 2, 0);

    // Test 5c: stop with nothing captured -> IDLE, rd_valid never high.
    do_arm();
    do_stop();
    check("empty_stop_state", state, IDLE);
    for (int i = 0; i < 3; i++) begin
      check("empty_stop_valid", rd_valid, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Downstream debug consumer of single_cycle_cpu's 64-bit debug_out bus: {PC[63:32], instruction[31:0]}.
- Records the last DEPTH retired {PC, instr} pairs in a circular buffer.
- Optionally freezes POST_TRIG entries after a PC-match trigger.
- Drains the captured history oldest-first over a valid/ready read port, replacing $display-based tracing in bench and FPGA bring-up.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
XLEN, 32, width of PC and instruction fields; entry width is 2*XLEN
POST_TRIG, 4, entries captured after (not including) the trigger entry; 0 <= POST_TRIG < DEPTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
trace_in  in  2*XLEN  {pc, instr}, same packing as debug_out
trace_valid  in  1  trace_in holds a retired instruction this cycle
arm  in  1  start a new capture (honoured in IDLE only)
stop  in  1  manual end of capture (honoured in CAPTURE only)
trig_en  in  1  enable PC-match trigger
trig_pc  in  XLEN  trigger PC value
rd_valid  out  1  rd_data holds a valid entry
rd_ready  in  1  consumer accepts entry
rd_data  out  2*XLEN  oldest unread entry
rd_last  out  1  rd_data is the final entry
count  out  $clog2(DEPTH)+1  entries held
overflow  out  1  sticky: at least one entry was overwritten during this capture
state  out  2  IDLE=0, CAPTURE=1, POST=2, DRAIN=3

Behaviour:
- Reset (async, on rst high): state=IDLE; wr_ptr, rd_ptr, count, post_cnt=0; overflow=0; rd_valid=0; rd_last=0. Storage array is not reset. rd_data is don't-care while rd_valid=0.
- IDLE:
  - trace_valid ignored.
  - arm=1 -> next cycle CAPTURE; wr_ptr, count, overflow cleared on that edge.
- CAPTURE and POST, write rule (per trace_valid=1 cycle):
  - mem[wr_ptr] <= trace_in; wr_ptr increments modulo DEPTH.
  - count increments, saturating at DEPTH.
  - Write with count==DEPTH sets overflow (sticky until next arm).
- CAPTURE:
  - Trigger = trig_en & trace_valid & (trace_in[2*XLEN-1:XLEN]==trig_pc).
  - Trigger entry is written.
  - On trigger: POST_TRIG==0 -> DRAIN; else post_cnt <= POST_TRIG and go to POST.
  - stop=1 -> DRAIN next cycle; a same-cycle trace_valid entry is still written.
  - Trigger and stop in the same cycle: stop wins, go to DRAIN.
  - stop with count==0: go to IDLE.
- POST:
  - Each write decrements post_cnt.
  - The write that takes post_cnt 1->0 moves state to DRAIN next cycle.
  - trig_en, trig_pc and stop are ignored.
- Entering DRAIN: rd_ptr <= (wr_ptr - count) mod DEPTH, using the post-write values.
- DRAIN:
  - Writes inhibited; arm ignored.
  - rd_valid = (count != 0); rd_data = mem[rd_ptr] (combinational read of register array); rd_last = rd_valid & (count==1).
  - rd_valid is first high 1 cycle after the final write.
  - Handshake rd_valid & rd_ready: rd_ptr increments mod DEPTH; count decrements.
  - Transfer with rd_last=1 -> IDLE next cycle.
  - rd_valid, once high, stays high and rd_data stays stable until accepted.
- Pointer wrap: DEPTH power of two, natural modulo by truncation.
- rst asserted in any state (incl. mid-drain): immediate return to IDLE; the partial capture is lost.

Decomposition:
- Package trace_pkg:
  - typedef trace_state_e (IDLE, CAPTURE, POST, DRAIN).
  - typedef trace_entry_t struct packed {pc, instr} sized by XLEN.
  - localparam TRACE_XLEN=32.
- One sub-module, trace_ram: DEPTH x 2*XLEN register array, one synchronous write port, one asynchronous read port. Keeps the FSM separate from storage.

Test Plan:
- Arm, feed 10 entries PC=0x00..0x24 step 4, stop -> count=10, overflow=0, drain returns PC 0x00..0x24 in order; rd_last on PC 0x24; state IDLE afterwards.
- Arm, feed 20 entries PC=0x00..0x4C, stop -> overflow=1, count=16, drain returns PC 0x10..0x4C, exercising wr_ptr/rd_ptr wrap.
- Arm with trig_en=1, trig_pc=0x20, feed PC=0x00..0x7C -> DRAIN after PC 0x30 written (4 post entries); drained PCs 0x00..0x30; PCs 0x34+ not stored.
- Backpressure in DRAIN: rd_ready toggles 1,0,0,1,... -> rd_data stable while stalled; no entry lost or duplicated; exactly count transfers.
- Assert rst for 1 ns (async, between clock edges) mid-drain after 3 of 8 reads -> state=IDLE, rd_valid=0, count=0 immediately, before the next clk edge; re-arm captures cleanly.
- Corner cases: arm while in DRAIN is ignored; stop and trigger in the same cycle -> DRAIN with no POST phase; stop with count=0 -> IDLE, rd_valid never asserts.
